rect_fill_engine: RTL and testbench



---
 rtl/rect_fill_engine.sv | 165 ++++++++++++++++
 tb/tb_rect_fill_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// rect_fill_engine
//   Takes one rectangle fill command (origin, size, 8-bit colour), clips it to
//   the visible screen and walks the clipped area row-major (x fastest).
//   It issues one pixel request per covered pixel to the pixel writer, and the
//   writer's ready paces those requests.
//
// Ports
//   clk, rst           : clock and asynchronous active-high reset
//   clear_screen_done  : from pixel writer; commands are not accepted while low
//   cmd_valid/cmd_ready: command handshake (cmd_ready is combinational)
//   cmd_x/y/w/h/rgb    : rectangle origin, size (0 = empty) and fill colour
//   busy               : high while a command is in SETUP or EMIT
//   pixel_en           : pixel request valid
//   pixel_rgb/x/y      : registered pixel colour and coordinates
//   pixel_wr_done      : pixel writer ready; transfer = pixel_en && pixel_wr_done
module rect_fill_engine #(
  parameter int SCREEN_W = 256,
  parameter int SCREEN_H = 192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_screen_done,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_x,
  input  logic [7:0] cmd_y,
  input  logic [7:0] cmd_w,
  input  logic [7:0] cmd_h,
  input  logic [7:0] cmd_rgb,
  output logic       busy,
  output logic       pixel_en,
  output logic [7:0] pixel_rgb,
  output logic [7:0] pixel_x,
  output logic [7:0] pixel_y,
  input  logic       pixel_wr_done
);

  typedef enum logic [1:0] {IDLE, SETUP, EMIT} state_t;

  // Clip limits and off-screen threshold in 9 bits so the end-coordinate sums
  // can exceed 255 without wrapping.
  localparam logic [8:0] X_MAX = 9'(SCREEN_W - 1);
  localparam logic [8:0] Y_MAX = 9'(SCREEN_H - 1);
  localparam logic [8:0] Y_LIM = 9'(SCREEN_H);

  state_t     state_q, state_d;
  logic [7:0] x0_q, x0_d;
  logic [7:0] y0_q, y0_d;
  logic [7:0] w_q, w_d;
  logic [7:0] h_q, h_d;
  logic [7:0] rgb_q, rgb_d;
  logic [7:0] x_end_q, x_end_d;
  logic [7:0] y_end_q, y_end_d;
  logic       pixel_en_q, pixel_en_d;
  logic [7:0] pixel_x_q, pixel_x_d;
  logic [7:0] pixel_y_q, pixel_y_d;
  logic [7:0] pixel_rgb_q, pixel_rgb_d;

  logic [8:0] x_sum, y_sum;
  logic       empty_cmd;
  logic       xfer;

  assign cmd_ready = (state_q == IDLE) && clear_screen_done;
  assign busy      = (state_q != IDLE);
  assign pixel_en  = pixel_en_q;
  assign pixel_x   = pixel_x_q;
  assign pixel_y   = pixel_y_q;
  assign pixel_rgb = pixel_rgb_q;

  // Inclusive end coordinates; only meaningful when w and h are non-zero.
  assign x_sum     = {1'b0, x0_q} + {1'b0, w_q} - 9'd1;
  assign y_sum     = {1'b0, y0_q} + {1'b0, h_q} - 9'd1;
  assign empty_cmd = (w_q == 8'd0) || (h_q == 8'd0) || ({1'b0, y0_q} >= Y_LIM);
  assign xfer      = pixel_en_q && pixel_wr_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x0_q        <= 8'd0;
      y0_q        <= 8'd0;
      w_q         <= 8'd0;
      h_q         <= 8'd0;
      rgb_q       <= 8'd0;
      x_end_q     <= 8'd0;
      y_end_q     <= 8'd0;
      pixel_en_q  <= 1'b0;
      pixel_x_q   <= 8'd0;
      pixel_y_q   <= 8'd0;
      pixel_rgb_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      rgb_q       <= rgb_d;
      x_end_q     <= x_end_d;
      y_end_q     <= y_end_d;
      pixel_en_q  <= pixel_en_d;
      pixel_x_q   <= pixel_x_d;
      pixel_y_q   <= pixel_y_d;
      pixel_rgb_q <= pixel_rgb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    rgb_d       = rgb_q;
    x_end_d     = x_end_q;
    y_end_d     = y_end_q;
    pixel_en_d  = pixel_en_q;
    pixel_x_d   = pixel_x_q;
    pixel_y_d   = pixel_y_q;
    pixel_rgb_d = pixel_rgb_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          x0_d    = cmd_x;
          y0_d    = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          rgb_d   = cmd_rgb;
          state_d = SETUP;
        end
      end

      SETUP: begin
        x_end_d = (x_sum > X_MAX) ? X_MAX[7:0] : x_sum[7:0];
        y_end_d = (y_sum > Y_MAX) ? Y_MAX[7:0] : y_sum[7:0];
        if (empty_cmd) begin
          state_d = IDLE;
        end else begin
          pixel_x_d   = x0_q;
          pixel_y_d   = y0_q;
          pixel_rgb_d = rgb_q;
          pixel_en_d  = 1'b1;
          state_d     = EMIT;
        end
      end

      EMIT: begin
        // Outputs hold while the writer is not ready; advance only on transfer.
        if (xfer) begin
          if (pixel_x_q != x_end_q) begin
            pixel_x_d = pixel_x_q + 8'd1;
          end else if (pixel_y_q != y_end_q) begin
            pixel_x_d = x0_q;
            pixel_y_d = pixel_y_q + 8'd1;
          end else begin
            pixel_en_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_screen_done;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x, cmd_y, cmd_w, cmd_h, cmd_rgb;
  logic       busy;
  logic       pixel_en;
  logic [7:0] pixel_rgb, pixel_x, pixel_y;
  logic       pixel_wr_done;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] rgb;
  } pix_t;

  pix_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   xfer_cnt = 0;
  int   rdy_mode = 0;  // 0: toggle every cycle, 1: hold low

  rect_fill_engine #(.SCREEN_W(256), .SCREEN_H(192)) dut (
    .clk(clk),
    .rst(rst),
    .clear_screen_done(clear_screen_done),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .cmd_w(cmd_w),
    .cmd_h(cmd_h),
    .cmd_rgb(cmd_rgb),
    .busy(busy),
    .pixel_en(pixel_en),
    .pixel_rgb(pixel_rgb),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .pixel_wr_done(pixel_wr_done)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_rect(input int xa, input int xb, input int ya, input int yb,
                           input logic [7:0] rgb);
    pix_t p;
    for (int y = ya; y <= yb; y++) begin
      for (int x = xa; x <= xb; x++) begin
        p.x = 8'(x);
        p.y = 8'(y);
        p.rgb = rgb;
        exp_q.push_back(p);
      end
    end
  endtask

  // Downstream ready generator, updated just after each rising edge.
  initial begin
    pixel_wr_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) pixel_wr_done = ~pixel_wr_done;
      else               pixel_wr_done = 1'b0;
    end
  end

  // Monitor: a transfer seen at the falling edge completes on the next rising edge.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (!rst && pixel_en && pixel_wr_done) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", {pixel_x, pixel_y}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("pix%0d_x", xfer_cnt), pixel_x, e.x);
          chk($sformatf("pix%0d_y", xfer_cnt), pixel_y, e.y);
          chk($sformatf("pix%0d_rgb", xfer_cnt), pixel_rgb, e.rgb);
          $display("pixel %0d: x=%0d y=%0d rgb=0x%02h", xfer_cnt, pixel_x, pixel_y, pixel_rgb);
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                          input logic [7:0] h, input logic [7:0] rgb);
    int guard = 0;
    while (!cmd_ready && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("cmd_ready_timeout", int'(cmd_ready), 1);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_rgb = rgb;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    $display("cmd: x=%0d y=%0d w=%0d h=%0d rgb=0x%02h", x, y, w, h, rgb);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_ready"}, int'(cmd_ready), 1);
  endtask

  initial begin
    int stable_bad;
    int guard;
    rst = 1'b1;
    clear_screen_done = 1'b0;
    cmd_valid = 1'b0;
    cmd_x = 8'd0; cmd_y = 8'd0; cmd_w = 8'd0; cmd_h = 8'd0; cmd_rgb = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pixel_en", int'(pixel_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_xyrgb", {pixel_x, pixel_y, pixel_rgb}, 0);
    rst = 1'b0;

    // 1: held off until clear_screen_done; test-2 rectangle is the held command.
    push_rect(10, 12, 20, 21, 8'hE3);
    cmd_x = 8'd10; cmd_y = 8'd20; cmd_w = 8'd3; cmd_h = 8'd2; cmd_rgb = 8'hE3;
    cmd_valid = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("gated_ready", int'(cmd_ready), 0);
      chk("gated_busy", int'(busy), 0);
    end
    chk("gated_pixel_en", int'(pixel_en), 0);
    clear_screen_done = 1'b1;
    #1;
    chk("ready_after_csd", int'(cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("setup_busy", int'(busy), 1);
    chk("setup_pixel_en", int'(pixel_en), 0);
    @(posedge clk);
    #1;
    chk("first_pixel_en", int'(pixel_en), 1);
    wait_done("rect3x2", 200);

    // 3: clipping at right and bottom edges.
    push_rect(250, 255, 190, 191, 8'h5A);
    send_cmd(8'd250, 8'd190, 8'd20, 8'd10, 8'h5A);
    wait_done("clip", 300);

    // 4: empty and off-screen commands.
    send_cmd(8'd5, 8'd5, 8'd0, 8'd4, 8'h11);
    chk("w0_busy_setup", int'(busy), 1);
    @(posedge clk); #1;
    chk("w0_idle", int'(busy), 0);
    chk("w0_pixel_en", int'(pixel_en), 0);
    send_cmd(8'd5, 8'd5, 8'd4, 8'd0, 8'h22);
    @(posedge clk); #1;
    chk("h0_idle", int'(busy), 0);
    chk("h0_pixel_en", int'(pixel_en), 0);
    send_cmd(8'd5, 8'd200, 8'd5, 8'd5, 8'h33);
    @(posedge clk); #1;
    chk("offscr_idle", int'(busy), 0);
    chk("offscr_pixel_en", int'(pixel_en), 0);
    repeat (3) @(posedge clk);
    #1;

    // 5: backpressure for 50 cycles.
    rdy_mode = 1;
    push_rect(0, 1, 0, 0, 8'h55);
    send_cmd(8'd0, 8'd0, 8'd2, 8'd1, 8'h55);
    @(posedge clk); #1;
    stable_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!(pixel_en && pixel_x == 8'd0 && pixel_y == 8'd0 && pixel_rgb == 8'h55))
        stable_bad++;
      @(posedge clk); #1;
    end
    chk("backpressure_unstable_cycles", stable_bad, 0);
    rdy_mode = 0;
    wait_done("bp", 100);

    // 6: reset in the middle of a 4x4 rectangle after 5 transfers.
    xfer_cnt = 0;
    push_rect(100, 103, 50, 50, 8'h1C);
    push_rect(100, 100, 51, 51, 8'h1C);
    send_cmd(8'd100, 8'd50, 8'd4, 8'd4, 8'h1C);
    guard = 0;
    while (xfer_cnt < 5 && guard < 200) begin
      @(posedge clk);
      #3;
      guard++;
    end
    chk("abort_reach5", xfer_cnt, 5);
    rst = 1'b1;
    #1;
    chk("abort_pixel_en", int'(pixel_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_xyrgb", {pixel_x, pixel_y, pixel_rgb}, 0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    stable_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (pixel_en || busy) stable_bad++;
    end
    chk("post_reset_quiet", stable_bad, 0);
    chk("post_reset_xfers", xfer_cnt, 5);
    chk("post_reset_pending", exp_q.size(), 0);
    push_rect(5, 6, 7, 8, 8'hC3);
    send_cmd(8'd5, 8'd7, 8'd2, 8'd2, 8'hC3);
    wait_done("after_reset", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
